lamp_cmd_issuer: RTL and testbench

- Master side of the lamp-control interface: the block that drives ActiveLamps.
- Accepts lamp commands through a valid/ready request port and buffers them in a small FIFO.
- Issues each command as a one-hot tcode together with ulight and lenght, holding them for a fixed window.
- Samples active_lights at the end of each window and returns it as a one-cycle response.

---
 rtl/lamp_cmd_issuer.sv | 196 +++++++++++++++++++
 tb/tb_lamp_cmd_issuer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_cmd_issuer.sv
// rtl/lamp_cmd_issuer.sv - lamp command issuer: request FIFO, one-hot tcode hold/gap sequencer, response capture (optional stats: LAMP_CMD_ISSUER_STATS_EN)
module lamp_cmd_issuer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
`ifdef LAMP_CMD_ISSUER_STATS_EN
  ,
  parameter int CNT_W       = 8
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [3:0] req_ulight,
  input  logic [3:0] req_len,
  output logic [3:0] tcode,
  output logic [3:0] ulight,
  output logic [3:0] lenght,
  input  logic [3:0] active_lights,
  output logic       resp_valid,
  output logic [3:0] resp_lights,
  output logic [1:0] resp_op,
  output logic       busy
`ifdef LAMP_CMD_ISSUER_STATS_EN
  ,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] lit_cnt
`endif
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW   = AW + 1;
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pop, finish, push;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count, count_n;
  logic          full, empty;
  logic [1:0]    head_op;
  logic [3:0]    head_ul, head_len;
  logic [1:0]    cur_op;

  assign full  = (count == NW'(FIFO_DEPTH));
  assign empty = (count == '0);
  // Abort wins over a same-edge push; full blocks push even if a pop happens.
  assign push  = req_valid && !full && !abort;
  assign {head_op, head_ul, head_len} = mem[rd_ptr];

  // Next-state logic: sequence IDLE -> HOLD -> GAP, popping when a command starts.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = HOLD;
          cnt_n   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          finish  = 1'b1;
          state_n = GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = HOLD;
            cnt_n   = HOLD_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      pop     = 1'b0;
      finish  = 1'b0;
    end
  end

  // Occupancy after this edge, used for the registered ready and busy flags.
  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + NW'(1);
    else if (pop && !push) count_n = count - NW'(1);
    if (abort)             count_n = '0;
  end

  // FSM state and window counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_op, req_ulight, req_len};
  end

  // FIFO pointers, occupancy and the derived ready/busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_n;
      req_ready <= (count_n != NW'(FIFO_DEPTH));
      busy      <= (state_n != IDLE) || (count_n != '0);
    end
  end

  // Lamp drive and response capture; tcode is non-zero only while in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcode       <= 4'b0000;
      ulight      <= 4'b0000;
      lenght      <= 4'b0000;
      cur_op      <= 2'd0;
      resp_valid  <= 1'b0;
      resp_lights <= 4'b0000;
      resp_op     <= 2'd0;
    end else begin
      if (pop) begin
        tcode  <= 4'b0001 << head_op;
        ulight <= head_ul;
        lenght <= head_len;
        cur_op <= head_op;
      end else if (state_n != HOLD) begin
        tcode <= 4'b0000;
      end
      resp_valid <= finish;
      if (finish) begin
        resp_lights <= active_lights;
        resp_op     <= cur_op;
      end
    end
  end

`ifdef LAMP_CMD_ISSUER_STATS_EN
  // Saturating response statistics; abort leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      lit_cnt    <= '0;
    end else if (resp_valid) begin
      if (issued_cnt != '1) issued_cnt <= issued_cnt + CNT_W'(1);
      if ((resp_lights != 4'b0000) && (lit_cnt != '1)) lit_cnt <= lit_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_lamp_cmd_issuer.sv
// tb/tb_lamp_cmd_issuer.sv - self-checking bench for lamp_cmd_issuer with a timeline model
module tb_lamp_cmd_issuer;

  localparam int DEPTH    = 4;
  localparam int HOLD     = 4;
  localparam int GAP      = 1;
  localparam int TB_CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [3:0] req_ulight = 4'd0;
  logic [3:0] req_len = 4'd0;
  logic [3:0] tcode, ulight, lenght;
  logic [3:0] active_lights = 4'b0101;
  logic       resp_valid;
  logic [3:0] resp_lights;
  logic [1:0] resp_op;
  logic       busy;
`ifdef LAMP_CMD_ISSUER_STATS_EN
  logic [TB_CNT_W-1:0] issued_cnt, lit_cnt;
`endif

  lamp_cmd_issuer #(
    .FIFO_DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP)
`ifdef LAMP_CMD_ISSUER_STATS_EN
    ,
    .CNT_W(TB_CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .abort(abort),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_ulight(req_ulight),
    .req_len(req_len),
    .tcode(tcode),
    .ulight(ulight),
    .lenght(lenght),
    .active_lights(active_lights),
    .resp_valid(resp_valid),
    .resp_lights(resp_lights),
    .resp_op(resp_op),
    .busy(busy)
`ifdef LAMP_CMD_ISSUER_STATS_EN
    ,
    .issued_cnt(issued_cnt),
    .lit_cnt(lit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] ul;
    logic [3:0] ln;
  } cmd_t;

  cmd_t mq[$];
  cmd_t cur;
  bit   cur_valid;
  int   k, cur_start, next_free;
  logic [3:0] exp_tcode, exp_ul, exp_ln, exp_rl;
  logic [1:0] exp_rop;
  logic       exp_rv, exp_ready, exp_busy;
  logic [TB_CNT_W-1:0] exp_iss, exp_lit;

  // A command occupies edges [start, start+HOLD); the next may start GAP edges after it ends.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cur_valid = 0; k = 0; next_free = 0; cur_start = 0;
      exp_tcode = 0; exp_ul = 0; exp_ln = 0; exp_rl = 0; exp_rop = 0;
      exp_rv = 0; exp_ready = 1; exp_busy = 0; exp_iss = 0; exp_lit = 0;
    end else begin
      k++;
      if (exp_rv) begin
        if (exp_iss != '1) exp_iss = exp_iss + 1'b1;
        if (exp_rl != 0 && exp_lit != '1) exp_lit = exp_lit + 1'b1;
      end
      exp_rv = 0;
      if (abort) begin
        mq.delete();
        cur_valid = 0;
        next_free = k;
      end else begin
        if (cur_valid && k == cur_start + HOLD) begin
          exp_rv = 1; exp_rl = active_lights; exp_rop = cur.op;
          cur_valid = 0;
          next_free = k + GAP;
        end
        if (!cur_valid && k >= next_free && mq.size() > 0) begin
          cur = mq.pop_front();
          cur_valid = 1; cur_start = k;
          exp_ul = cur.ul; exp_ln = cur.ln;
        end
        if (req_valid && exp_ready) mq.push_back(cmd_t'({req_op, req_ulight, req_len}));
      end
      exp_tcode = cur_valid ? (4'b0001 << cur.op) : 4'b0000;
      exp_ready = (mq.size() < DEPTH);
      exp_busy  = cur_valid || (mq.size() != 0) || (k < next_free);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tcode", tcode, exp_tcode);
      chk("ulight", ulight, exp_ul);
      chk("lenght", lenght, exp_ln);
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, exp_busy);
      chk("resp_valid", resp_valid, exp_rv);
      chk("resp_lights", resp_lights, exp_rl);
      chk("resp_op", resp_op, exp_rop);
`ifdef LAMP_CMD_ISSUER_STATS_EN
      chk("issued_cnt", issued_cnt, exp_iss);
      chk("lit_cnt", lit_cnt, exp_lit);
`endif
    end
  end

  // Monitor: response ops and a tcode trace for the literal checks.
  int         resp_ops[$];
  logic [3:0] trace[$];
  bit         rec_on = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) resp_ops.push_back(int'(resp_op));
      if (rec_on) trace.push_back(tcode);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input logic [1:0] op, input logic [3:0] ul, input logic [3:0] ln);
    req_valid = 1; req_op = op; req_ulight = ul; req_len = ln;
    tick();
    req_valid = 0;
  endtask

  int rv[$], rl[$];
  int n, first_stall, stall_len;
  bit acc;
  int exp_vals[7] = '{1, 0, 2, 0, 4, 0, 8};
  int exp_lens[7] = '{4, 1, 4, 1, 4, 1, 4};
  int exp_t3[6]   = '{0, 1, 2, 3, 0, 1};

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_tcode", tcode, 4'b0000);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    rst_n = 1;
    tick();

    // 1: single command, 1-cycle latency, 4-cycle hold, one response
    resp_ops.delete();
    req_valid = 1; req_op = 0; req_ulight = 4'b1010; req_len = 4'b1100;
    tick();
    req_valid = 0;
    chk("t1_latency_tcode", tcode, 4'b0000);
    tick();
    chk("t1_tcode", tcode, 4'b0001);
    chk("t1_ulight", ulight, 4'b1010);
    chk("t1_lenght", lenght, 4'b1100);
    repeat (3) tick();
    chk("t1_tcode_last", tcode, 4'b0001);
    tick();
    chk("t1_tcode_off", tcode, 4'b0000);
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_resp_lights", resp_lights, 4'b0101);
    chk("t1_resp_op", resp_op, 2'd0);
    tick();
    chk("t1_resp_pulse", resp_valid, 1'b0);
    repeat (3) tick();
    chk("t1_resp_count", resp_ops.size(), 1);

    // 2: four back-to-back ops
    resp_ops.delete(); trace.delete(); rec_on = 1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_op = 2'(i); req_ulight = 4'b1010; req_len = 4'b1100;
      tick();
    end
    req_valid = 0;
    repeat (25) tick();
    rec_on = 0;
    rv.delete(); rl.delete();
    foreach (trace[i]) begin
      if (rv.size() == 0 || rv[rv.size()-1] != int'(trace[i])) begin
        rv.push_back(int'(trace[i])); rl.push_back(1);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    chk("t2_run_count", rv.size(), 9);
    for (int i = 0; i < 7; i++) begin
      if (i + 1 < rv.size()) begin
        chk("t2_run_val", rv[i+1], exp_vals[i]);
        chk("t2_run_len", rl[i+1], exp_lens[i]);
      end
    end
    chk("t2_resp_count", resp_ops.size(), 4);
    for (int i = 0; i < 4; i++) if (i < resp_ops.size()) chk("t2_resp_op", resp_ops[i], i);

    // 3: hold req_valid high until the FIFO fills
    resp_ops.delete();
    n = 0; first_stall = -1; stall_len = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      req_valid = 1; req_op = 2'(n); req_ulight = 4'(n); req_len = ~4'(n);
      acc = req_ready;
      tick();
      if (acc) n++;
      else begin
        if (first_stall < 0) first_stall = n;
        stall_len++;
      end
    end
    req_valid = 0;
    chk("t3_accepted_before_stall", first_stall, 5);
    chk("t3_stall_len", stall_len, 2);
    repeat (30) tick();
    chk("t3_resp_count", resp_ops.size(), 6);
    for (int i = 0; i < 6; i++) if (i < resp_ops.size()) chk("t3_resp_op", resp_ops[i], exp_t3[i]);

    // 4: abort in the 2nd HOLD cycle with two queued, plus a discarded push
    resp_ops.delete();
    push1(2'd1, 4'b0011, 4'b0001);
    push1(2'd2, 4'b0101, 4'b0010);
    push1(2'd3, 4'b0110, 4'b0011);
    req_valid = 1; req_op = 2'd0; abort = 1;
    tick();
    req_valid = 0; abort = 0;
    chk("t4_tcode", tcode, 4'b0000);
    chk("t4_busy", busy, 1'b0);
    chk("t4_ready", req_ready, 1'b1);
    chk("t4_resp_valid", resp_valid, 1'b0);
    repeat (10) tick();
    chk("t4_no_resp", resp_ops.size(), 0);

    // 5: asynchronous reset mid-HOLD
    resp_ops.delete();
    push1(2'd2, 4'b1111, 4'b0111);
    tick();
    chk("t5_tcode_before", tcode, 4'b0100);
    rst_n = 0;
    #1;
    chk("t5_async_tcode", tcode, 4'b0000);
    chk("t5_async_ulight", ulight, 4'b0000);
    chk("t5_async_lenght", lenght, 4'b0000);
    chk("t5_async_ready", req_ready, 1'b1);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_resp_valid", resp_valid, 1'b0);
    tick(); tick();
    rst_n = 1;
    tick();
    push1(2'd3, 4'b0001, 4'b0010);
    repeat (10) tick();
    chk("t5_resume_count", resp_ops.size(), 1);
    if (resp_ops.size() > 0) chk("t5_resume_op", resp_ops[0], 3);

`ifdef LAMP_CMD_ISSUER_STATS_EN
    // 6: statistics counters and saturation
    rst_n = 0; tick(); rst_n = 1; tick();
    active_lights = 4'b0000;
    push1(2'd0, 4'b1010, 4'b1100);
    repeat (8) tick();
    active_lights = 4'b0110;
    push1(2'd1, 4'b1010, 4'b1100);
    repeat (8) tick();
    chk("t6_issued", issued_cnt, 2'd2);
    chk("t6_lit", lit_cnt, 2'd1);
    for (int i = 0; i < 3; i++) push1(2'(i), 4'b1010, 4'b1100);
    repeat (20) tick();
    chk("t6_issued_sat", issued_cnt, 2'd3);
    chk("t6_lit_sat", lit_cnt, 2'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
